icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC register and a slow, handshaked instruction memory.
- On a hit it returns instrF combinationally in the same cycle as pcF.
- On a miss it asserts stallI, fills the whole line from memory one word per handshake, then resumes.
- The pipeline's hazard logic ORs stallI into stallF/stallD, so pcF stays frozen during a miss.

Parameters:
- LINES, 16: number of cache lines; power of 2, at least 2.
- WORDS, 4: 32-bit words per line; power of 2, at least 2.
- Derived: WB = log2(WORDS), IB = log2(LINES), TB = 30 - WB - IB.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pcF  in  32  fetch address. Bits [1:0] are ignored.
- instrF  out  32  instruction for pcF. Valid only when stallI=0.
- stallI  out  1  high while pcF misses or a fill is in progress.
- inval  in  1  single-cycle pulse that invalidates all lines.
- mem_req  out  1  word read request to instruction memory.
- mem_addr  out  32  word-aligned read address. Bits [1:0] are always 0.
- mem_ack  in  1  memory has returned mem_rdata this cycle.
- mem_rdata  in  32  read data. Sampled only when mem_req & mem_ack.

Behaviour:
- Address split: word = pcF[WB+1:2], index = pcF[WB+IB+1:WB+2], tag = pcF[31:WB+IB+2].
- Storage per line: valid bit, TB-bit tag, WORDS x 32 data. All registers, no memory macros.
- hit = valid[index] & (tag_store[index] == tag). Purely combinational from pcF and the arrays.
- States: IDLE and FILL. A 2-bit state register is allowed for encoding margin.
- IDLE:
  - hit: instrF = data[index][word], stallI = 0.
  - miss: instrF = 32'h0 (NOP), stallI = 1.
  - On a miss, the next edge latches miss_tag and miss_index from pcF, clears the word counter cnt to 0, clears valid[index], and enters FILL.
- FILL:
  - stallI = 1, instrF = 32'h0.
  - mem_req = 1, mem_addr = {miss_tag, miss_index, cnt, 2'b00}.
  - mem_addr is driven only from latched state; it must not follow pcF.
  - On each edge with mem_ack = 1: data[miss_index][cnt] <= mem_rdata, cnt <= cnt + 1.
  - On the ack with cnt == WORDS-1: tag_store[miss_index] <= miss_tag, valid[miss_index] <= 1, go to IDLE. cnt wraps to 0.
  - The line is filled in order from word 0; there is no critical-word-first.
- Handshake rules:
  - mem_req rises on the cycle after the miss is detected.
  - mem_req stays high continuously until the last ack, with mem_addr stable between acks.
  - mem_ack may arrive in the first FILL cycle; the minimum is 1 cycle per word.
  - Back-to-back acks advance cnt every cycle.
  - mem_ack while not in FILL is ignored.
  - mem_req = 0 and mem_addr = 0 in IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 detect cycle + WORDS ack cycles. The first IDLE cycle after the fill is a hit with stallI = 0.
  - Minimum miss penalty is WORDS + 1 stall cycles.
- Conflict miss: the fill overwrites the resident line unconditionally. The cache is read-only, so there is no writeback.
- inval:
  - In IDLE, the next edge clears all valid bits. stallI in that same cycle is still evaluated against the old arrays.
  - In FILL, all valid bits are cleared, the fill continues to completion, and the filled line is marked valid.
  - inval is honoured in the same edge as fill completion: the filled line ends valid and all others end invalid.
- reset:
  - Next edge clears all valid bits and sets state = IDLE, cnt = 0, mem_req = 0.
  - Mid-fill, reset aborts immediately with no further request. Any ack arriving in the reset cycle is discarded.
  - Tag and data arrays are not reset.
- Outputs after reset: stallI = 1 for any pcF (all lines invalid), instrF = 0, mem_req = 0, mem_addr = 0.

Test Plan:
- Cold miss: reset, then pcF = 0x00400000, ack every cycle with rdata 0x20080005, 0x20090007, 0x01095020, 0xAC0A0054 for addresses 0x00400000, 0x04, 0x08, 0x0C. Expect stallI = 1 for 5 cycles, the four requests in order, then instrF = 0x20080005 with stallI = 0.
- Hits in the same line: after the previous fill, step pcF through 0x00400004, 0x08, 0x0C. Expect instrF = 0x20090007, 0x01095020, 0xAC0A0054 with no stall and mem_req = 0.
- Slow memory: miss at 0x00400040 with ack delayed 3 cycles per word. Expect mem_addr held at each word address for 4 cycles, stallI high for 17 cycles, then a hit.
- Conflict: fill 0x00400000, then miss at 0x00401000 (same index 0). Expect a refill from 0x00401000. Returning to 0x00400000 misses again and refetches.
- Reset mid-fill: reset asserted after 2 acks of a fill. Expect mem_req = 0 on the next cycle and the same pcF to miss again, starting from word 0.
- inval: pulse inval while line 0 is valid. Expect the next access to 0x00400000 to miss. A pulse during a fill leaves only the filling line valid.

Source files
------------

// File: rtl/icache_fetch.sv
// ============================================================================
//  Module      : icache_fetch
//  Description : Direct-mapped read-only instruction cache with line fill
//                over a req/ack instruction-memory handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_fetch #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        stallI,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int WB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - WB - IB;
    localparam logic [WB-1:0] c_lastWord = WB'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [WB-1:0]     r_cnt;
    logic [TB-1:0]     r_missTag;
    logic [IB-1:0]     r_missIndex;
    logic [LINES-1:0]  r_valid;
    logic [TB-1:0]     r_tag  [LINES];
    logic [31:0]       r_data [LINES][WORDS];

    logic [WB-1:0]     w_word;
    logic [IB-1:0]     w_index;
    logic [TB-1:0]     w_tag;
    logic              w_hit;
    logic              w_fill;
    logic              w_lastAck;
    logic              w_unused;

    assign w_word    = pcF[WB+1:2];
    assign w_index   = pcF[WB+IB+1:WB+2];
    assign w_tag     = pcF[31:WB+IB+2];
    assign w_unused  = &{1'b0, pcF[1:0]};

    assign w_hit     = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_fill    = (r_state == S_FILL);
    assign w_lastAck = w_fill && mem_ack && (r_cnt == c_lastWord);

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (!w_hit)    w_stateNext = S_FILL;
            S_FILL:  if (w_lastAck) w_stateNext = S_IDLE;
            default:                w_stateNext = S_IDLE;
        endcase
    end

    // Request address comes only from latched miss state so it cannot follow pcF.
    always_comb begin
        stallI   = w_fill || !w_hit;
        instrF   = (!w_fill && w_hit) ? r_data[w_index][w_word] : 32'h0;
        mem_req  = w_fill;
        mem_addr = w_fill ? {r_missTag, r_missIndex, r_cnt, 2'b00} : 32'h0;
    end

    // Control state: valid bits, fill counter and the latched miss address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                S_IDLE: begin
                    if (inval)
                        r_valid <= '0;
                    if (!w_hit) begin
                        r_missTag          <= w_tag;
                        r_missIndex        <= w_index;
                        r_cnt              <= '0;
                        r_valid[w_index]   <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (inval)
                        r_valid <= '0;
                    // Later assignment wins: a completing line survives a same-edge inval.
                    if (mem_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_lastAck)
                            r_valid[r_missIndex] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; an ack during reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_fill && mem_ack) begin
            r_data[r_missIndex][r_cnt] <= mem_rdata;
            if (w_lastAck)
                r_tag[r_missIndex] <= r_missTag;
        end
    end

endmodule

`default_nettype wire
